// File: rtl/smiley_hit_detector.sv
// Pixel-rate smiley/obstacle collision detector with per-frame edge summary.
// Optional macro HIT_COUNTER_EN adds a saturating per-frame overlap pixel count.
module smiley_hit_detector #(
   parameter int OBJECT_WIDTH_X = 64,
   parameter int OBJECT_HIGHT_Y = 64,
   parameter int EDGE_BAND      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        startOfFrame,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic [10:0] topLeftX,
   input  logic [10:0] topLeftY,
   input  logic        smileyDrawingRequest,
   input  logic        brickDrawingRequest,
`ifdef HIT_COUNTER_EN
   output logic [15:0] frameHitCount,
`endif
   output logic        collision,
   output logic [3:0]  HitEdgeCode,
   output logic        frameHit,
   output logic [3:0]  frameEdgeCode
);

   typedef enum logic [1:0] {
      IDLE_ST     = 2'd0,
      ARMED_ST    = 2'd1,
      REPORTED_ST = 2'd2
   } state_t;

   localparam logic signed [11:0] W_S      = 12'(OBJECT_WIDTH_X);
   localparam logic signed [11:0] H_S      = 12'(OBJECT_HIGHT_Y);
   localparam logic signed [11:0] BAND_S   = 12'(EDGE_BAND);
   localparam logic signed [11:0] W_BAND_S = 12'(OBJECT_WIDTH_X - EDGE_BAND);
   localparam logic signed [11:0] H_BAND_S = 12'(OBJECT_HIGHT_Y - EDGE_BAND);

   state_t             state_q, state_d;
   logic               collision_q, collision_d;
   logic [3:0]         hit_code_q, hit_code_d;
   logic               frame_hit_q, frame_hit_d;
   logic [3:0]         frame_code_q, frame_code_d;
   logic               acc_hit_q, acc_hit_d;
   logic [3:0]         acc_code_q, acc_code_d;

   logic signed [11:0] off_x_s, off_y_s;
   logic               in_x_s, in_y_s;
   logic [3:0]         code_s;
   logic               overlap_s;
   logic               armed_s;
   logic               pulse_s;
   logic               acc_en_s;

   // Edge classification on the live pixel; topLeft is sign-extended to 12 bits.
   always_comb begin
      off_x_s   = $signed({1'b0, pixelX}) - $signed({topLeftX[10], topLeftX});
      off_y_s   = $signed({1'b0, pixelY}) - $signed({topLeftY[10], topLeftY});
      in_x_s    = (off_x_s >= 12'sd0) && (off_x_s < W_S);
      in_y_s    = (off_y_s >= 12'sd0) && (off_y_s < H_S);
      code_s[3] = in_x_s && (off_x_s < BAND_S);
      code_s[1] = in_x_s && (off_x_s >= W_BAND_S);
      code_s[2] = in_y_s && (off_y_s < BAND_S);
      code_s[0] = in_y_s && (off_y_s >= H_BAND_S);
      overlap_s = smileyDrawingRequest & brickDrawingRequest;
   end

   // Frame FSM; an overlap coincident with startOfFrame already belongs to the new frame.
   always_comb begin
      state_d     = state_q;
      pulse_s     = 1'b0;
      armed_s     = startOfFrame | (state_q == ARMED_ST);
      case (state_q)
         IDLE_ST:     if (startOfFrame) state_d = ARMED_ST; else state_d = IDLE_ST;
         ARMED_ST:    state_d = ARMED_ST;
         REPORTED_ST: if (startOfFrame) state_d = ARMED_ST; else state_d = REPORTED_ST;
         default:     state_d = IDLE_ST;
      endcase
      // Holding off while a pulse is out keeps collision from ever lasting two cycles.
      if (armed_s && overlap_s && !collision_q) begin
         pulse_s = 1'b1;
         state_d = REPORTED_ST;
      end else begin
         pulse_s = 1'b0;
      end
      collision_d = pulse_s;
      if (pulse_s) hit_code_d = code_s; else hit_code_d = hit_code_q;
   end

   // Per-frame accumulation, latched into the summary at startOfFrame.
   always_comb begin
      acc_en_s     = overlap_s && (armed_s || (state_q == REPORTED_ST));
      frame_hit_d  = frame_hit_q;
      frame_code_d = frame_code_q;
      acc_hit_d    = acc_hit_q;
      acc_code_d   = acc_code_q;
      if (startOfFrame) begin
         frame_hit_d  = acc_hit_q;
         frame_code_d = acc_code_q;
         acc_hit_d    = overlap_s;
         acc_code_d   = overlap_s ? code_s : 4'b0000;
      end else if (acc_en_s) begin
         acc_hit_d    = 1'b1;
         acc_code_d   = acc_code_q | code_s;
      end else begin
         acc_hit_d    = acc_hit_q;
         acc_code_d   = acc_code_q;
      end
   end

   // Main state and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE_ST;
         collision_q  <= 1'b0;
         hit_code_q   <= 4'b0000;
         frame_hit_q  <= 1'b0;
         frame_code_q <= 4'b0000;
         acc_hit_q    <= 1'b0;
         acc_code_q   <= 4'b0000;
      end else begin
         state_q      <= state_d;
         collision_q  <= collision_d;
         hit_code_q   <= hit_code_d;
         frame_hit_q  <= frame_hit_d;
         frame_code_q <= frame_code_d;
         acc_hit_q    <= acc_hit_d;
         acc_code_q   <= acc_code_d;
      end
   end

   assign collision     = collision_q;
   assign HitEdgeCode   = hit_code_q;
   assign frameHit      = frame_hit_q;
   assign frameEdgeCode = frame_code_q;

`ifdef HIT_COUNTER_EN
   logic [15:0] acc_cnt_q, acc_cnt_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // Saturating overlap pixel counter, latched and reseeded like the edge summary.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      acc_cnt_d   = acc_cnt_q;
      if (startOfFrame) begin
         frame_cnt_d = acc_cnt_q;
         acc_cnt_d   = overlap_s ? 16'd1 : 16'd0;
      end else if (acc_en_s && (acc_cnt_q != 16'hFFFF)) begin
         acc_cnt_d   = acc_cnt_q + 16'd1;
      end else begin
         acc_cnt_d   = acc_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_cnt_q   <= 16'd0;
         frame_cnt_q <= 16'd0;
      end else begin
         acc_cnt_q   <= acc_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frameHitCount = frame_cnt_q;
`endif

endmodule

// File: tb/tb_smiley_hit_detector.sv
// Directed self-checking bench for smiley_hit_detector (honours HIT_COUNTER_EN).
module tb_smiley_hit_detector;

   logic        clk = 1'b0;
   logic        reset;
   logic        startOfFrame;
   logic [10:0] pixelX, pixelY, topLeftX, topLeftY;
   logic        smileyDrawingRequest, brickDrawingRequest;
   logic        collision;
   logic [3:0]  HitEdgeCode;
   logic        frameHit;
   logic [3:0]  frameEdgeCode;
`ifdef HIT_COUNTER_EN
   logic [15:0] frameHitCount;
`endif

   int n_vec = 0;
   int n_err = 0;

   smiley_hit_detector dut (
      .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
      .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
      .smileyDrawingRequest(smileyDrawingRequest), .brickDrawingRequest(brickDrawingRequest),
`ifdef HIT_COUNTER_EN
      .frameHitCount(frameHitCount),
`endif
      .collision(collision), .HitEdgeCode(HitEdgeCode),
      .frameHit(frameHit), .frameEdgeCode(frameEdgeCode)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one pixel; ovl selects an overlap, sof the frame pulse.
   task automatic drive(input int x, input int y, input logic ovl, input logic sof);
      pixelX               = 11'(x);
      pixelY               = 11'(y);
      smileyDrawingRequest = ovl;
      brickDrawingRequest  = ovl;
      startOfFrame         = sof;
   endtask

   initial begin
      reset    = 1'b1;
      topLeftX = 11'd100;
      topLeftY = 11'd100;
      drive(101, 130, 1'b1, 1'b0);
      tick(); tick(); tick();
      check("rst_collision", 16'(collision), 16'd0);
      check("rst_hitcode", 16'(HitEdgeCode), 16'd0);
      check("rst_framehit", 16'(frameHit), 16'd0);
      check("rst_framecode", 16'(frameEdgeCode), 16'd0);

      reset = 1'b0;
      drive(0, 0, 1'b0, 1'b0); tick();
      check("idle_collision", 16'(collision), 16'd0);

      // frame 1: left-edge hit
      drive(0, 0, 1'b0, 1'b1); tick();
      drive(101, 130, 1'b1, 1'b0); tick();
      check("f1_pulse", 16'(collision), 16'd1);
      check("f1_code", 16'(HitEdgeCode), 16'b1000);
      drive(0, 0, 1'b0, 1'b0); tick();
      check("f1_pulse_one_cycle", 16'(collision), 16'd0);

      // frame 2: corner first, then left pixel without pulse
      drive(0, 0, 1'b0, 1'b1); tick();
      check("f1_sum_hit", 16'(frameHit), 16'd1);
      check("f1_sum_code", 16'(frameEdgeCode), 16'b1000);
      drive(163, 163, 1'b1, 1'b0); tick();
      check("f2_corner_pulse", 16'(collision), 16'd1);
      check("f2_corner_code", 16'(HitEdgeCode), 16'b0011);
      drive(101, 130, 1'b1, 1'b0); tick();
      check("f2_second_nopulse", 16'(collision), 16'd0);
      drive(0, 0, 1'b0, 1'b0); tick();
      drive(101, 130, 1'b1, 1'b0); tick();
      check("f2_late_nopulse", 16'(collision), 16'd0);
      check("f2_code_held", 16'(HitEdgeCode), 16'b0011);

      // frame 3: top then bottom
      drive(0, 0, 1'b0, 1'b1); tick();
      check("f2_sum_code", 16'(frameEdgeCode), 16'b1011);
      drive(130, 101, 1'b1, 1'b0); tick();
      check("f3_top_pulse", 16'(collision), 16'd1);
      check("f3_top_code", 16'(HitEdgeCode), 16'b0100);
      drive(0, 0, 1'b0, 1'b0); tick();
      drive(130, 162, 1'b1, 1'b0); tick();
      check("f3_bottom_nopulse", 16'(collision), 16'd0);

      // frame 4: empty
      drive(0, 0, 1'b0, 1'b1); tick();
      check("f3_sum_hit", 16'(frameHit), 16'd1);
      check("f3_sum_code", 16'(frameEdgeCode), 16'b0101);
      drive(0, 0, 1'b0, 1'b0); tick(); tick(); tick();

      // frame 5 starts; empty frame summary, HitEdgeCode retained
      drive(0, 0, 1'b0, 1'b1); tick();
      check("f4_sum_hit", 16'(frameHit), 16'd0);
      check("f4_sum_code", 16'(frameEdgeCode), 16'd0);
      check("f4_code_kept", 16'(HitEdgeCode), 16'b0100);
      drive(0, 0, 1'b0, 1'b0); tick();

      // frame 6 starts with a coincident overlap
      drive(101, 130, 1'b1, 1'b1); tick();
      check("sof_ovl_pulse", 16'(collision), 16'd1);
      check("sof_ovl_code", 16'(HitEdgeCode), 16'b1000);
      check("sof_ovl_old_hit", 16'(frameHit), 16'd0);
      check("sof_ovl_old_code", 16'(frameEdgeCode), 16'd0);
      drive(0, 0, 1'b0, 1'b0); tick();
      check("sof_ovl_no_repeat", 16'(collision), 16'd0);

      // frame 7: out-of-box interior overlap, band boundaries, partial-axis hit
      drive(0, 0, 1'b0, 1'b1); tick();
      check("sof_ovl_new_hit", 16'(frameHit), 16'd1);
      check("sof_ovl_new_code", 16'(frameEdgeCode), 16'b1000);
      drive(50, 130, 1'b1, 1'b0); tick();
      check("outside_x_pulse", 16'(collision), 16'd1);
      check("outside_x_code", 16'(HitEdgeCode), 16'b0000);
      drive(104, 130, 1'b1, 1'b0); tick();
      drive(159, 130, 1'b1, 1'b0); tick();
      drive(160, 40, 1'b1, 1'b0); tick();
      drive(0, 0, 1'b0, 1'b0); tick();
      drive(0, 0, 1'b0, 1'b1); tick();
      check("f7_sum_hit", 16'(frameHit), 16'd1);
      check("f7_sum_code", 16'(frameEdgeCode), 16'b0010);

`ifdef HIT_COUNTER_EN
      drive(0, 0, 1'b0, 1'b0); tick();
      for (int i = 0; i < 10; i++) begin
         drive(120 + i, 130, 1'b1, 1'b0); tick();
      end
      drive(0, 0, 1'b0, 1'b0); tick();
      drive(0, 0, 1'b0, 1'b1); tick();
      check("hit_count_10", frameHitCount, 16'd10);
      drive(0, 0, 1'b0, 1'b1); tick();
      check("hit_count_empty", frameHitCount, 16'd0);
`endif

      drive(0, 0, 1'b0, 1'b0); tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
